// File: rtl/mem_wb_stage_pkg.sv
// Shared types and defaults for the MEM stage and MEM/WB register.
// FSM state encoding, write-back select encoding, width defaults.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 3;

  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic WB_SEL_ALU = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data memory req/ready bus between the MEM stage and data memory.
// master: core side (drives Req/We/Addr/Wdata), slave: memory side.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              Dmem_Req;
  logic              Dmem_We;
  logic [ADDR_W-1:0] Dmem_Addr;
  logic [DATA_W-1:0] Dmem_Wdata;
  logic [DATA_W-1:0] Dmem_Rdata;
  logic              Dmem_Ready;

  modport master (
    output Dmem_Req,
    output Dmem_We,
    output Dmem_Addr,
    output Dmem_Wdata,
    input  Dmem_Rdata,
    input  Dmem_Ready
  );

  modport slave (
    input  Dmem_Req,
    input  Dmem_We,
    input  Dmem_Addr,
    input  Dmem_Wdata,
    output Dmem_Rdata,
    output Dmem_Ready
  );

endinterface

// File: rtl/mem_wb_stage_reg.sv
// Plain MEM/WB pipeline register (mem_wb_reg) with load/bubble control.
// i_load=0 writes a bubble; i_mem_ld updates load data; i_fault is a pulse.
module mem_wb_reg
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_we,
  input  logic                  i_sel,
  input  logic                  i_mem_ld,
  input  logic                  i_fault,
  input  logic [DATA_W-1:0]     i_result,
  input  logic [DATA_W-1:0]     i_rdata,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  o_we,
  output logic                  o_sel,
  output logic                  o_fault,
  output logic [DATA_W-1:0]     o_mem_out,
  output logic [DATA_W-1:0]     o_result,
  output logic [REG_ADDR_W-1:0] o_rd
);

  logic                  r_we;
  logic                  r_sel;
  logic                  r_fault;
  logic [DATA_W-1:0]     r_mem_out;
  logic [DATA_W-1:0]     r_result;
  logic [REG_ADDR_W-1:0] r_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_sel     <= WB_SEL_ALU;
      r_fault   <= 1'b0;
      r_mem_out <= '0;
      r_result  <= '0;
      r_rd      <= '0;
    end else begin
      r_we    <= i_load & i_we;
      r_fault <= i_fault;
      if (i_load) begin
        r_sel    <= i_sel;
        r_result <= i_result;
        r_rd     <= i_rd;
      end else begin
        r_sel <= WB_SEL_ALU;
      end
      if (i_mem_ld)
        r_mem_out <= i_rdata;
    end
  end

  assign o_we      = r_we;
  assign o_sel     = r_sel;
  assign o_fault   = r_fault;
  assign o_mem_out = r_mem_out;
  assign o_result  = r_result;
  assign o_rd      = r_rd;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: issues loads/stores over dmem, stalls upstream, feeds MEM/WB.
// Ports: *_MEM from EX/MEM, dmem bus (master), *_WB to write-back, Stall_MEM.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid_MEM,
  input  logic                  Write_Enable_MEM,
  input  logic                  Write_Back_Sel_MEM,
  input  logic                  Mem_Write_MEM,
  input  logic [DATA_W-1:0]     Result_MEM,
  input  logic [DATA_W-1:0]     Store_Data_MEM,
  input  logic [REG_ADDR_W-1:0] Rd_MEM,
  output logic                  Stall_MEM,
  mem_wb_stage_if.master        dmem,
  output logic                  Write_Enable_WB,
  output logic                  Write_Back_Sel_WB,
  output logic [DATA_W-1:0]     Mem_Out_WB,
  output logic [DATA_W-1:0]     Result_WB,
  output logic [REG_ADDR_W-1:0] Rd_WB,
  output logic                  Mem_Fault_WB
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  logic w_memop;
  logic w_store;
  logic w_req;
  logic w_stall;
  logic w_load;
  logic w_we;
  logic w_sel;
  logic w_mem_ld;
  logic w_fault;

  assign w_store = Mem_Write_MEM;
  assign w_memop = Valid_MEM & (Mem_Write_MEM | Write_Back_Sel_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Ready wins over timeout on the last WAIT cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_load      = 1'b0;
    w_we        = 1'b0;
    w_sel       = WB_SEL_ALU;
    w_mem_ld    = 1'b0;
    w_fault     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_memop) begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_load = 1'b1;
          w_we   = Valid_MEM & Write_Enable_MEM;
        end
      end
      WAIT: begin
        if (dmem.Dmem_Ready) begin
          w_load      = 1'b1;
          w_we        = Write_Enable_MEM & ~w_store;
          w_sel       = w_store ? WB_SEL_ALU : WB_SEL_MEM;
          w_mem_ld    = ~w_store;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_fault     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
    endcase
  end

  assign Stall_MEM       = w_stall & ~rst;
  assign dmem.Dmem_Req   = w_req & ~rst;
  assign dmem.Dmem_We    = w_store;
  assign dmem.Dmem_Addr  = Result_MEM[ADDR_W-1:0];
  assign dmem.Dmem_Wdata = Store_Data_MEM;

  mem_wb_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_we      (w_we),
    .i_sel     (w_sel),
    .i_mem_ld  (w_mem_ld),
    .i_fault   (w_fault),
    .i_result  (Result_MEM),
    .i_rdata   (dmem.Dmem_Rdata),
    .i_rd      (Rd_MEM),
    .o_we      (Write_Enable_WB),
    .o_sel     (Write_Back_Sel_WB),
    .o_fault   (Mem_Fault_WB),
    .o_mem_out (Mem_Out_WB),
    .o_result  (Result_WB),
    .o_rd      (Rd_WB)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios then random ops vs a model.
// Model tracks one outstanding access and the expected WB register.
module tb_mem_wb_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Valid_MEM = 1'b0;
  logic        Write_Enable_MEM = 1'b0;
  logic        Write_Back_Sel_MEM = 1'b0;
  logic        Mem_Write_MEM = 1'b0;
  logic [15:0] Result_MEM = '0;
  logic [15:0] Store_Data_MEM = '0;
  logic [2:0]  Rd_MEM = '0;
  logic        Stall_MEM;
  logic        Write_Enable_WB;
  logic        Write_Back_Sel_WB;
  logic [15:0] Mem_Out_WB;
  logic [15:0] Result_WB;
  logic [2:0]  Rd_WB;
  logic        Mem_Fault_WB;

  always #5 clk = ~clk;

  mem_wb_stage_if dmem ();

  mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rst                (rst),
    .Valid_MEM          (Valid_MEM),
    .Write_Enable_MEM   (Write_Enable_MEM),
    .Write_Back_Sel_MEM (Write_Back_Sel_MEM),
    .Mem_Write_MEM      (Mem_Write_MEM),
    .Result_MEM         (Result_MEM),
    .Store_Data_MEM     (Store_Data_MEM),
    .Rd_MEM             (Rd_MEM),
    .Stall_MEM          (Stall_MEM),
    .dmem               (dmem),
    .Write_Enable_WB    (Write_Enable_WB),
    .Write_Back_Sel_WB  (Write_Back_Sel_WB),
    .Mem_Out_WB         (Mem_Out_WB),
    .Result_WB          (Result_WB),
    .Rd_WB              (Rd_WB),
    .Mem_Fault_WB       (Mem_Fault_WB)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is an access outstanding, how long has it waited,
  // and what the WB register should hold after the next edge.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  logic        e_we, e_sel, e_fault;
  logic [15:0] e_mem = '0;
  logic [15:0] e_res;
  logic [2:0]  e_rd;
  bit          e_full;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic v, input logic we,
                     input logic sel, input logic mw,
                     input logic [15:0] res, input logic [15:0] sd,
                     input logic [2:0] rd, input logic rdy,
                     input logic [15:0] rdat);
    bit memop, st, done, tmo, x_req, x_stall;
    @(negedge clk);
    rst                = rs;
    Valid_MEM          = v;
    Write_Enable_MEM   = we;
    Write_Back_Sel_MEM = sel;
    Mem_Write_MEM      = mw;
    Result_MEM         = res;
    Store_Data_MEM     = sd;
    Rd_MEM             = rd;
    dmem.Dmem_Ready    = rdy;
    dmem.Dmem_Rdata    = rdat;
    #1;
    memop   = v && (mw || sel);
    st      = mw;
    done    = m_busy && rdy;
    tmo     = m_busy && !rdy && (m_age == T - 1);
    x_req   = !rs && !m_busy && memop;
    x_stall = !rs && (x_req || (m_busy && !done && !tmo));
    chk("stall", 32'(Stall_MEM), 32'(x_stall));
    chk("req", 32'(dmem.Dmem_Req), 32'(x_req));
    if (x_req) begin
      chk("dmem_we", 32'(dmem.Dmem_We), 32'(st));
      chk("dmem_addr", 32'(dmem.Dmem_Addr), 32'(res));
      chk("dmem_wdata", 32'(dmem.Dmem_Wdata), 32'(sd));
    end
    e_fault = 1'b0;
    e_full  = 1'b0;
    if (rs) begin
      m_busy = 1'b0;
      e_we = 1'b0; e_sel = 1'b0; e_res = '0; e_rd = '0; e_mem = '0;
      e_full = 1'b1;
    end else if (!m_busy) begin
      if (memop) begin
        m_busy = 1'b1;
        m_age  = 0;
        e_we   = 1'b0;
      end else begin
        e_we = v && we; e_sel = 1'b0; e_res = res; e_rd = rd;
        e_full = 1'b1;
      end
    end else if (done) begin
      m_busy = 1'b0;
      e_we = we && !st; e_sel = !st; e_res = res; e_rd = rd;
      e_full = 1'b1;
      if (!st) e_mem = rdat;
    end else if (tmo) begin
      m_busy  = 1'b0;
      e_we    = 1'b0;
      e_fault = 1'b1;
    end else begin
      m_age++;
      e_we = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("we_wb", 32'(Write_Enable_WB), 32'(e_we));
    chk("fault_wb", 32'(Mem_Fault_WB), 32'(e_fault));
    chk("mem_out_wb", 32'(Mem_Out_WB), 32'(e_mem));
    if (e_full) begin
      chk("sel_wb", 32'(Write_Back_Sel_WB), 32'(e_sel));
      chk("result_wb", 32'(Result_WB), 32'(e_res));
      chk("rd_wb", 32'(Rd_WB), 32'(e_rd));
    end
  endtask

  logic        r_v, r_we, r_sel, r_mw, r_rs, r_rdy;
  logic [15:0] r_res, r_sd, r_rdat;
  logic [2:0]  r_rd;

  initial begin
    dmem.Dmem_Ready = 1'b0;
    dmem.Dmem_Rdata = '0;

    cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
    cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 16'h0);

    // ALU op
    cyc(0, 1, 1, 0, 0, 16'h1234, 16'h0, 3'd3, 0, 16'h0);
    chk("alu_res", 32'(Result_WB), 32'h1234);
    chk("alu_rd", 32'(Rd_WB), 32'd3);

    // Load, Ready three cycles after Req
    cyc(0, 1, 1, 1, 0, 16'h0040, 16'h0, 3'd5, 0, 16'h0);
    cyc(0, 1, 1, 1, 0, 16'h0040, 16'h0, 3'd5, 0, 16'h0);
    cyc(0, 1, 1, 1, 0, 16'h0040, 16'h0, 3'd5, 0, 16'h0);
    cyc(0, 1, 1, 1, 0, 16'h0040, 16'h0, 3'd5, 1, 16'hBEEF);
    chk("load_data", 32'(Mem_Out_WB), 32'hBEEF);
    chk("load_sel", 32'(Write_Back_Sel_WB), 32'd1);

    // Store with WE set, Ready after one cycle
    cyc(0, 1, 1, 0, 1, 16'h0010, 16'hA5A5, 3'd2, 0, 16'h0);
    cyc(0, 1, 1, 0, 1, 16'h0010, 16'hA5A5, 3'd2, 1, 16'h7777);
    chk("store_we", 32'(Write_Enable_WB), 32'd0);

    // Timeout: Req cycle plus T WAIT cycles without Ready, then stray Ready
    for (int i = 0; i <= T; i++)
      cyc(0, 1, 1, 1, 0, 16'h0080, 16'h0, 3'd1, 0, 16'h0);
    chk("tmo_fault", 32'(Mem_Fault_WB), 32'd1);
    cyc(0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 1, 16'h1111);
    cyc(0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 16'h0);

    // Reset while waiting, Ready arrives afterwards
    cyc(0, 1, 1, 1, 0, 16'h0090, 16'h0, 3'd4, 0, 16'h0);
    cyc(0, 1, 1, 1, 0, 16'h0090, 16'h0, 3'd4, 0, 16'h0);
    cyc(1, 1, 1, 1, 0, 16'h0090, 16'h0, 3'd4, 0, 16'h0);
    cyc(0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
    cyc(0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 1, 16'h2222);
    chk("rst_mem_out", 32'(Mem_Out_WB), 32'd0);

    // Load immediately followed by ALU op
    cyc(0, 1, 1, 1, 0, 16'h0022, 16'h0, 3'd7, 0, 16'h0);
    cyc(0, 1, 1, 1, 0, 16'h0022, 16'h0, 3'd7, 1, 16'h1357);
    cyc(0, 1, 1, 0, 0, 16'h5555, 16'h0, 3'd6, 0, 16'h0);
    chk("ld_alu_res", 32'(Result_WB), 32'h5555);
    chk("ld_alu_mem", 32'(Mem_Out_WB), 32'h1357);

    // Random traffic; MEM inputs held while an access is outstanding
    r_v = 0; r_we = 0; r_sel = 0; r_mw = 0;
    r_res = '0; r_sd = '0; r_rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!m_busy) begin
        r_v   = ($urandom % 4) != 0;
        r_we  = 1'($urandom);
        r_sel = 1'($urandom);
        r_mw  = ($urandom % 3) == 0;
        r_res = 16'($urandom);
        r_sd  = 16'($urandom);
        r_rd  = 3'($urandom);
      end
      r_rs   = ($urandom % 60) == 0;
      r_rdy  = m_busy ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      r_rdat = 16'($urandom);
      cyc(r_rs, r_v, r_we, r_sel, r_mw, r_res, r_sd, r_rd, r_rdy, r_rdat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the 16-bit pipelined core.
- Takes the EX/MEM instruction and issues loads/stores to data memory over a req/ready handshake.
- Stalls upstream while an access is outstanding.
- Registers the values consumed by the write-back mux: Mem_Out_WB, Result_WB, Write_Back_Sel_WB, Write_Enable_WB and the destination register.

Parameters:
- DATA_W, 16, datapath and memory data width
- ADDR_W, 16, data memory address width
- REG_ADDR_W, 3, register file address width
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before fault; 1..255

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- Valid_MEM  in  1  instruction present at MEM inputs
- Write_Enable_MEM  in  1  instruction writes a register
- Write_Back_Sel_MEM  in  1  1: load, write-back from memory; 0: from ALU
- Mem_Write_MEM  in  1  store
- Result_MEM  in  DATA_W  ALU result; memory address for loads/stores (low ADDR_W bits)
- Store_Data_MEM  in  DATA_W  store data
- Rd_MEM  in  REG_ADDR_W  destination register
- Stall_MEM  out  1  freeze IF..EX/MEM registers this cycle
- Dmem_Req  out  1  memory request strobe
- Dmem_We  out  1  1: write, 0: read
- Dmem_Addr  out  ADDR_W  access address
- Dmem_Wdata  out  DATA_W  write data
- Dmem_Rdata  in  DATA_W  read data, valid when Dmem_Ready=1
- Dmem_Ready  in  1  single-cycle completion pulse
- Write_Enable_WB  out  1  registered write enable
- Write_Back_Sel_WB  out  1  registered select
- Mem_Out_WB  out  DATA_W  registered load data
- Result_WB  out  DATA_W  registered ALU result
- Rd_WB  out  REG_ADDR_W  registered destination
- Mem_Fault_WB  out  1  registered one-cycle fault flag

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - FSM returns to IDLE and the timeout counter is 0.
  - All *_WB outputs are 0.
  - Dmem_Req is 0 and Stall_MEM is 0.
- Operation classes:
  - Memop = Valid_MEM & (Mem_Write_MEM | Write_Back_Sel_MEM).
  - Store = Mem_Write_MEM. Store wins if both bits are set, and no write-back occurs.
- FSM states: IDLE, WAIT.
- IDLE, no memop:
  - No stall.
  - Next edge: Write_Enable_WB <= Valid_MEM & Write_Enable_MEM, Write_Back_Sel_WB <= 0, Result_WB <= Result_MEM, Rd_WB <= Rd_MEM.
  - Latency is 1 cycle.
- IDLE, memop:
  - Dmem_Req=1 combinationally for exactly this cycle.
  - Dmem_We=Store, Dmem_Addr=Result_MEM[ADDR_W-1:0], Dmem_Wdata=Store_Data_MEM.
  - Stall_MEM=1.
  - Go to WAIT and clear the counter.
  - Write a bubble into WB (Write_Enable_WB<=0).
- WAIT, no Dmem_Ready:
  - Stall_MEM=1, Dmem_Req=0, counter increments.
  - Write a bubble into WB.
  - MEM inputs are held stable by the stall.
- WAIT, Dmem_Ready=1:
  - Stall_MEM=0, so upstream advances.
  - Next edge: Write_Enable_WB <= Write_Enable_MEM & ~Store, Write_Back_Sel_WB <= ~Store, Result_WB <= Result_MEM, Rd_WB <= Rd_MEM.
  - For loads only, Mem_Out_WB <= Dmem_Rdata.
  - Go to IDLE.
- Load-use latency: 1 cycle plus memory latency. Minimum memory latency is 1 (Ready no earlier than the cycle after Req).
- Mem_Out_WB holds its value on every edge that does not complete a load.
- Timeout:
  - In WAIT with counter == TIMEOUT_CYCLES-1 and no Ready: Stall_MEM=0, go to IDLE.
  - Next edge: Write_Enable_WB <= 0 and Mem_Fault_WB <= 1 for one cycle.
  - Mem_Fault_WB is 0 on all other edges.
- Dmem_Ready seen in IDLE (stray or late) is ignored: no state or output change.
- Ready on the timeout cycle counts as a normal completion. Ready takes priority over timeout.
- Reset asserted in WAIT: next edge returns to IDLE with all outputs at reset values. The outstanding access is abandoned and its later Ready is ignored.
- Back-to-back memops: each costs at least 2 cycles. Dmem_Req never asserts in two consecutive cycles.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1)
  - DATA_W/REG_ADDR_W defaults
  - the write-back select encoding (WB_SEL_MEM=1, WB_SEL_ALU=0)
- Natural sub-module: mem_wb_reg, the plain MEM/WB register with load and bubble controls. The FSM, counter and handshake stay in the top module.

Test Plan:
- ALU op: Valid=1, WE=1, Sel=0, Result=16'h1234, Rd=3 -> next cycle WE_WB=1, Result_WB=16'h1234, Rd_WB=3, Stall never high.
- Load at 16'h0040 with Ready 3 cycles after Req, Rdata=16'hBEEF -> Dmem_Req high exactly 1 cycle with We=0, Addr=16'h0040. Stall high 3 cycles. WE_WB=0 during stall, then WE_WB=1, Sel_WB=1, Mem_Out_WB=16'hBEEF.
- Store Addr=16'h0010, Data=16'hA5A5, Ready after 1 cycle -> Req with We=1, Wdata=16'hA5A5. WB stage gets WE_WB=0 (even if Write_Enable_MEM=1).
- Timeout with TIMEOUT_CYCLES=4 and no Ready -> Stall released after 4 WAIT cycles, Mem_Fault_WB pulses 1 cycle, WE_WB=0. A later stray Ready is ignored.
- rst asserted in WAIT, Ready arrives 2 cycles later -> all outputs 0, state IDLE, no WB write, Mem_Out_WB stays 0.
- Load immediately followed by ALU op -> ALU op reaches WB exactly 1 cycle after the load's WB write, and Mem_Out_WB keeps the load data.
